load_store_unit: RTL



---
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the single-cycle datapath and a
// req/ack data bus. It stalls the datapath while an access is in flight,
// drives byte-lane enables and replicated store data, and returns
// sign/zero-extended load data in the DONE cycle.
module load_store_unit #(
    parameter int AddressWidth  = 10,
    parameter int TimeoutCycles = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    mem_r_en_i,
    input  logic                    mem_wr_en_i,
    input  logic [AddressWidth-1:0] addr_i,
    input  logic [31:0]             wr_data_i,
    input  logic [2:0]              funct3_i,
    output logic                    stall_o,
    output logic [31:0]             r_data_o,
    output logic                    misaligned_o,
    output logic                    bus_err_o,
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    output logic [AddressWidth-1:0] bus_addr_o,
    output logic [3:0]              bus_be_o,
    output logic [31:0]             bus_wdata_o,
    input  logic                    bus_ack_i,
    input  logic [31:0]             bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Wide enough to hold TimeoutCycles-1 for any TimeoutCycles >= 1.
    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    state_t              state_reg, state_next;
    logic [CntWidth-1:0] cnt_reg;
    logic [2:0]          funct3_reg;
    logic [1:0]          addr_lo_reg;
    logic [31:0]         r_data_reg;
    logic                err_reg;

    logic        req;
    logic        legal;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        start;
    logic        finish_ack;
    logic        abort;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    // Decode the incoming request: legality, byte enables and lane-replicated store data.
    always_comb begin
        req     = mem_r_en_i | mem_wr_en_i;
        legal   = 1'b0;
        be_c    = 4'b0000;
        wdata_c = 32'h0;
        if (mem_wr_en_i) begin
            // Store takes priority when both enables are high.
            case (funct3_i)
                3'b000: begin
                    legal   = 1'b1;
                    be_c    = 4'b0001 << addr_i[1:0];
                    wdata_c = {4{wr_data_i[7:0]}};
                end
                3'b001: begin
                    legal   = ~addr_i[0];
                    be_c    = addr_i[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{wr_data_i[15:0]}};
                end
                3'b010: begin
                    legal   = (addr_i[1:0] == 2'b00);
                    be_c    = 4'b1111;
                    wdata_c = wr_data_i;
                end
                default: legal = 1'b0;
            endcase
        end else begin
            // Loads enable the lanes they read; store data is don't-care.
            case (funct3_i)
                3'b000, 3'b100: begin
                    legal = 1'b1;
                    be_c  = 4'b0001 << addr_i[1:0];
                end
                3'b001, 3'b101: begin
                    legal = ~addr_i[0];
                    be_c  = addr_i[1] ? 4'b1100 : 4'b0011;
                end
                3'b010: begin
                    legal = (addr_i[1:0] == 2'b00);
                    be_c  = 4'b1111;
                end
                default: legal = 1'b0;
            endcase
        end
    end

    // Select the addressed lane of the bus word and extend it per the registered funct3.
    always_comb begin
        lane_byte = bus_rdata_i[{addr_lo_reg, 3'b000} +: 8];
        lane_half = addr_lo_reg[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (funct3_reg)
            3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_ext = {24'h0, lane_byte};
            3'b101:  load_ext = {16'h0, lane_half};
            default: load_ext = bus_rdata_i;
        endcase
    end

    // Next-state logic plus the combinational stall/reject outputs.
    always_comb begin
        state_next   = state_reg;
        stall_o      = 1'b0;
        misaligned_o = 1'b0;
        start        = 1'b0;
        finish_ack   = 1'b0;
        abort        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (legal) begin
                        stall_o    = 1'b1;
                        start      = 1'b1;
                        state_next = BUSY;
                    end else begin
                        misaligned_o = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (bus_ack_i) begin
                    finish_ack = 1'b1;
                    state_next = DONE;
                end else if (cnt_reg == CntLast) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, bus request registers, timeout counter and captured load data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            funct3_reg  <= 3'b000;
            addr_lo_reg <= 2'b00;
            r_data_reg  <= 32'h0;
            err_reg     <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= 4'b0000;
            bus_wdata_o <= 32'h0;
        end else begin
            state_reg <= state_next;
            err_reg   <= abort;
            if (start) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= mem_wr_en_i;
                bus_addr_o  <= {addr_i[AddressWidth-1:2], 2'b00};
                bus_be_o    <= be_c;
                bus_wdata_o <= wdata_c;
                funct3_reg  <= funct3_i;
                addr_lo_reg <= addr_i[1:0];
                cnt_reg     <= '0;
                r_data_reg  <= 32'h0;
            end else if (state_reg == BUSY) begin
                if (finish_ack || abort) begin
                    bus_req_o  <= 1'b0;
                    cnt_reg    <= '0;
                    // Stores and aborted accesses return zero.
                    r_data_reg <= (finish_ack && !bus_we_o) ? load_ext : 32'h0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign bus_err_o = err_reg;
    assign r_data_o  = (state_reg == DONE) ? r_data_reg : 32'h0;

endmodule
